// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch stage feeding the ARM data-processing decoder.
//   Owns the PC and runs a request/acknowledge fetch from instruction memory,
//   then holds the word in the instruction register until downstream consumes it.
//   At most one fetch is outstanding, so a branch never needs a flush.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   halt             blocks the start of new memory requests
//   mem_req/addr     fetch request and byte address (always the PC)
//   mem_ack/rdata    memory completion and instruction word
//   ir, ir_valid     instruction register and its valid flag
//   ir_ready         downstream consumes ir this cycle
//   ir_pc, pc_plus8  address of the instruction in ir, and that plus 8 (R15 view)
//   branch_en/imm24  taken-branch redirect for the instruction being consumed
//   fetch_cnt        count of completed fetches
module ins_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_plus8,
    input  logic        branch_en,
    input  logic [23:0] branch_imm24,
    output logic [31:0] fetch_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] br_off, br_tgt;

    // ARM branch target: word offset sign-extended and scaled, relative to PC+8
    assign br_off = {{6{branch_imm24[23]}}, branch_imm24, 2'b00};
    assign br_tgt = ir_pc_q + 32'd8 + br_off;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = halt ? S_HALT : S_FETCH;
            // a request, once raised, is held until acknowledged; halt is not looked at here
            S_FETCH: if (mem_ack) begin
                ir_d    = mem_rdata;
                ir_pc_d = pc_q;
                cnt_d   = cnt_q + 32'd1;
                state_d = S_VALID;
            end
            S_VALID: if (ir_ready) begin
                pc_d    = branch_en ? br_tgt : ir_pc_q + PC_STEP;
                state_d = halt ? S_HALT : S_FETCH;
            end
            S_HALT:  state_d = halt ? S_HALT : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ir_pc_q <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req   = state_q == S_FETCH;
    assign ir_valid  = state_q == S_VALID;
    assign mem_addr  = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign pc_plus8  = ir_pc_q + 32'd8;
    assign fetch_cnt = cnt_q;
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: scripted scoreboard bench for ins_fetch
module tb_ins_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir_pc;
    logic [31:0] pc_plus8;
    logic        branch_en = 1'b0;
    logic [23:0] branch_imm24 = '0;
    logic [31:0] fetch_cnt;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    ins_fetch dut (
        .clk(clk), .rst(rst), .halt(halt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_pc(ir_pc), .pc_plus8(pc_plus8),
        .branch_en(branch_en), .branch_imm24(branch_imm24), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hE1A0_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory acknowledges the current request with the word stored at its address
    task automatic ack_now();
        mem_ack = 1'b1;
        mem_rdata = word_of(mem_addr);
        exp_q.push_back('{ir: word_of(exp_pc), pc: exp_pc});
        exp_cnt = exp_cnt + 32'd1;
        step();
        mem_ack = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic consume(input logic br, input logic [23:0] imm);
        ir_ready = 1'b1;
        branch_en = br;
        branch_imm24 = imm;
        exp_pc = br ? exp_pc + 32'd8 + {{6{imm[23]}}, imm, 2'b00} : exp_pc + 32'd4;
        step();
        ir_ready = 1'b0;
        branch_en = 1'b0;
        branch_imm24 = '0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL rst_ir: got %h want 0", ir); end
        n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        n_checks++; if (pc_plus8 !== 32'h8) begin n_fail++; $display("FAIL rst_pc_plus8: got %h want 8", pc_plus8); end
        n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_cnt: got %h want 0", fetch_cnt); end
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
    endtask

    task automatic test_zero_wait();
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_first_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_first_addr: got %h want 0", mem_addr); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid_early: got %b want 0", ir_valid); end
        ack_now();
        e = exp_q.pop_front();
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", ir_valid); end
        n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL zw_ir: got %h want %h", ir, e.ir); end
        n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL zw_ir_pc: got %h want 0", ir_pc); end
        n_checks++; if (pc_plus8 !== 32'h8) begin n_fail++; $display("FAIL zw_pc_plus8: got %h want 8", pc_plus8); end
        n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL zw_cnt1: got %0d want 1", fetch_cnt); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL zw_req_in_valid: got %b want 0", mem_req); end
        consume(1'b0, 24'h0);
        n_checks++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL zw_next_addr: got %h want 4", mem_addr); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_next_req: got %b want 1", mem_req); end
        ack_now();
        e = exp_q.pop_front();
        n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL zw_ir2: got %h want %h", ir, e.ir); end
        n_checks++; if (ir_pc !== e.pc) begin n_fail++; $display("FAIL zw_ir_pc2: got %h want %h", ir_pc, e.pc); end
        n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL zw_cnt2: got %0d want 2", fetch_cnt); end
        consume(1'b0, 24'h0);
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ws_req[%0d]: got %b want 1", i, mem_req); end
            n_checks++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h want %h", i, mem_addr, exp_pc); end
            n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid[%0d]: got %b want 0", i, ir_valid); end
            if (i < 3) step();
        end
        ack_now();
        e = exp_q.pop_front();
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid_after: got %b want 1", ir_valid); end
        n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL ws_ir: got %h want %h", ir, e.ir); end
        n_checks++; if (ir_pc !== e.pc) begin n_fail++; $display("FAIL ws_ir_pc: got %h want %h", ir_pc, e.pc); end
        consume(1'b0, 24'h0);
    endtask

    task automatic test_backpressure();
        ack_now();
        e = exp_q.pop_front();
        // stray acks and branch inputs while not consuming must change nothing
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            branch_en = 1'b1;
            branch_imm24 = 24'h123456;
            step();
            n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL bp_ir[%0d]: got %h want %h", i, ir, e.ir); end
            n_checks++; if (ir_pc !== e.pc) begin n_fail++; $display("FAIL bp_ir_pc[%0d]: got %h want %h", i, ir_pc, e.pc); end
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req[%0d]: got %b want 0", i, mem_req); end
            n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, ir_valid); end
            n_checks++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d want %0d", i, fetch_cnt, exp_cnt); end
        end
        mem_ack = 1'b0;
        mem_rdata = '0;
        branch_en = 1'b0;
        branch_imm24 = '0;
        consume(1'b0, 24'h0);
        n_checks++; if (mem_addr !== e.pc + 32'd4) begin n_fail++; $display("FAIL bp_next_addr: got %h want %h", mem_addr, e.pc + 32'd4); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL bp_next_req: got %b want 1", mem_req); end
    endtask

    task automatic test_branch();
        logic [23:0] imm[6];
        logic [31:0] tgt[6];
        imm = '{24'h00003A, 24'h000010, 24'hFFFFEC, 24'hFFFFFE, 24'hFFFFBD, 24'h000000};
        tgt = '{32'h100, 32'h148, 32'h100, 32'h100, 32'hFFFF_FFFC, 32'h4};
        for (int i = 0; i < 6; i++) begin
            ack_now();
            e = exp_q.pop_front();
            n_checks++; if (ir_pc !== e.pc) begin n_fail++; $display("FAIL br_ir_pc[%0d]: got %h want %h", i, ir_pc, e.pc); end
            n_checks++; if (pc_plus8 !== e.pc + 32'd8) begin n_fail++; $display("FAIL br_pc_plus8[%0d]: got %h want %h", i, pc_plus8, e.pc + 32'd8); end
            consume(1'b1, imm[i]);
            n_checks++; if (mem_addr !== tgt[i]) begin n_fail++; $display("FAIL br_target[%0d]: got %h want %h", i, mem_addr, tgt[i]); end
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL halt_req_held: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL halt_addr_held: got %h want %h", mem_addr, exp_pc); end
        ack_now();
        e = exp_q.pop_front();
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL halt_valid: got %b want 1", ir_valid); end
        n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL halt_ir: got %h want %h", ir, e.ir); end
        consume(1'b0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req[%0d]: got %b want 0", i, mem_req); end
            n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 0", i, ir_valid); end
            n_checks++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h want %h", i, mem_addr, exp_pc); end
            step();
        end
        halt = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== e.pc + 32'd4) begin n_fail++; $display("FAIL resume_addr: got %h want %h", mem_addr, e.pc + 32'd4); end
    endtask

    task automatic test_async_reset();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_fetch_req: got %b want 0", mem_req); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ar_fetch_valid: got %b want 0", ir_valid); end
        n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL ar_fetch_cnt: got %0d want 0", fetch_cnt); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_fetch_addr: got %h want 0", mem_addr); end
        exp_q.delete();
        exp_pc = 32'h0;
        exp_cnt = 32'h0;
        step();
        rst = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ar_restart_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_restart_addr: got %h want 0", mem_addr); end
        ack_now();
        e = exp_q.pop_front();
        n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL ar_ir: got %h want %h", ir, e.ir); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_drop: got %b want 0", ir_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_valid_req: got %b want 0", mem_req); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL ar_ir_clear: got %h want 0", ir); end
        n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL ar_cnt_clear: got %0d want 0", fetch_cnt); end
        halt = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_idle_halt_req: got %b want 0", mem_req); end
        halt = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ar_unhalt_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_unhalt_addr: got %h want 0", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_branch();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
- Instruction fetch stage directly upstream of the ARM data-processing decoder.
- Owns the PC and runs a request/acknowledge fetch from instruction memory.
- Holds the fetched word in an instruction register (IR) that drives the decoder's 32-bit instruction input.
- Presents the word with a valid/ready handshake and redirects the PC on branches resolved downstream (imm24 offset).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; address of the first fetch.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- halt  input  1  when high, no new memory request is started.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  fetch byte address; equals the PC.
- mem_ack  input  1  memory returns mem_rdata this cycle; ignored unless mem_req=1.
- mem_rdata  input  32  instruction word.
- ir  output  32  instruction register; feeds the decoder.
- ir_valid  output  1  ir holds an unconsumed instruction.
- ir_ready  input  1  downstream consumes ir this cycle.
- ir_pc  output  32  address of the instruction in ir.
- pc_plus8  output  32  ir_pc+8; the R15 read value for that instruction.
- branch_en  input  1  the instruction being consumed is a taken branch.
- branch_imm24  input  24  branch offset field of that instruction.
- fetch_cnt  output  32  count of completed fetches.

Behaviour:
- Reset (async, while rst=1):
  - state=S_IDLE; pc=RESET_PC; ir=0; ir_pc=RESET_PC; fetch_cnt=0.
  - mem_req=0, ir_valid=0.
- States S_IDLE, S_FETCH, S_VALID, S_HALT. Outputs decode from registered state only: mem_req=(state==S_FETCH), ir_valid=(state==S_VALID).
- mem_addr=pc at all times.
- pc_plus8=ir_pc+8, mod 2^32.
- S_IDLE: next edge goes to S_HALT if halt=1, else S_FETCH. The first request is visible in the first cycle after reset deassertion.
- S_FETCH:
  - mem_req=1 and mem_addr stay stable until mem_ack. A request is never withdrawn; halt is ignored here.
  - On mem_ack: ir<=mem_rdata, ir_pc<=pc, fetch_cnt<=fetch_cnt+1 (wraps at 2^32), go to S_VALID.
  - mem_ack in the same cycle mem_req first rises is legal. That gives zero-wait fetch latency: ir_valid is high the cycle after the request cycle.
- S_VALID:
  - ir, ir_pc stay stable while ir_ready=0.
  - On ir_ready=1, pc is loaded as follows:
    - if branch_en=1: pc <= ir_pc + 8 + sign_extend(branch_imm24)<<2, computed in 32 bits, wrapping mod 2^32;
    - else: pc <= ir_pc + PC_STEP.
  - Then go to S_HALT if halt=1, else S_FETCH.
  - branch_en and branch_imm24 are sampled only in S_VALID with ir_ready=1; they are ignored in every other state or cycle.
- S_HALT: mem_req=0, ir_valid=0, pc held. Go to S_FETCH on the first edge with halt=0.
- No prefetch: at most one outstanding request; throughput is at most one instruction per two cycles.
- Branch needs no flush: nothing is in flight while ir is valid.
- mem_ack outside S_FETCH has no effect on any state.
- Reset asserted mid-fetch or mid-hold: the in-flight request and ir content are discarded immediately, and fetch restarts at RESET_PC.
- Target arithmetic: offset is {{6{imm24[23]}},imm24,2'b00}. Example: imm24=24'hFFFFFE gives -8, so the branch targets itself.

Test Plan:
1. Reset release with RESET_PC=0, halt=0, memory acks zero-wait:
   - mem_req=1, mem_addr=0 in the first cycle.
   - Next cycle ir=mem_rdata, ir_valid=1, ir_pc=0, pc_plus8=8.
   - With ir_ready=1 the next fetch address is 4; fetch_cnt=1, then 2.
2. Wait states: mem_ack delayed 3 cycles.
   - mem_req and mem_addr are held constant for 4 cycles.
   - ir_valid stays 0 until the cycle after mem_ack.
3. Backpressure: ir_ready=0 for 5 cycles.
   - ir, ir_pc stable and mem_req=0 throughout.
   - On release the next mem_addr is ir_pc+4.
4. Branches:
   - ir_pc=0x100, branch_en=1, imm24=24'h000010 with ir_ready=1: next mem_addr=0x148.
   - imm24=24'hFFFFFE: next mem_addr=0x100.
   - ir_pc=0xFFFF_FFFC, imm24=0: next mem_addr=0x4 (wrap).
5. Halt:
   - halt=1 raised during S_FETCH: the request completes, ir_valid=1.
   - After consumption, mem_req=0 while halt=1.
   - halt=0 resumes with mem_addr=ir_pc+4.
6. Async reset:
   - Assert rst mid-S_FETCH (no ack) and mid-S_VALID: mem_req and ir_valid drop immediately, fetch_cnt=0.
   - After release the first mem_addr=RESET_PC.
